// File: rtl/br_pkg.sv
// Shared types and default sizes for the parametrised register bank.
package br_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } br_state_t;

  localparam int BR_DATA_W   = 32;
  localparam int BR_NUM_REGS = 32;

endpackage

// File: rtl/br_read_mux.sv
// One asynchronous read port: zero register, range check, same-cycle bypass, then storage.
module br_read_mux
  import br_pkg::*;
#(
  parameter int DATA_W   = BR_DATA_W,
  parameter int NUM_REGS = BR_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] ar,
  input  logic [ADDR_W-1:0] aw,
  input  logic              wr_ok,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  output logic [DATA_W-1:0] dr
);

  // Compared one bit wider so the range check stays meaningful for any NUM_REGS.
  localparam logic [ADDR_W:0] NUM_EXT = (ADDR_W + 1)'(NUM_REGS);

  logic in_range;

  always_comb begin
    in_range = ({1'b0, ar} < NUM_EXT);
    dr       = '0;
    if ((ZERO_REG != 0) && (ar == '0)) begin
      dr = '0;
    end else if (!in_range) begin
      dr = '0;
    end else if ((BYPASS != 0) && wr_ok && (aw == ar)) begin
      dr = din;
    end else begin
      dr = regs[ar];
    end
  end

endmodule

// File: rtl/br_param.sv
// Parametrised register bank: one write port, two async read ports, sequential clear engine.
module br_param
  import br_pkg::*;
#(
  parameter int DATA_W   = BR_DATA_W,
  parameter int NUM_REGS = BR_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [ADDR_W-1:0] AW,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [ADDR_W-1:0] AR1,
  input  logic [ADDR_W-1:0] AR2,
  output logic [DATA_W-1:0] DR1,
  output logic [DATA_W-1:0] DR2,
  input  logic              CLR,
  output logic              BUSY,
  output logic              WR_DROP
);

  localparam logic [ADDR_W:0]   NUM_EXT  = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] mem [NUM_REGS];
  br_state_t         state;
  logic [ADDR_W-1:0] ptr;
  logic              wr_ok;

  always_comb begin
    wr_ok = WE && !BUSY && ({1'b0, AW} < NUM_EXT) &&
            !((ZERO_REG != 0) && (AW == '0));
  end

  assign WR_DROP = WE & BUSY;

  // Storage: the sweep owns the array while clearing; wr_ok is already low then.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[AW] <= DataIn;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      ptr   <= '0;
      BUSY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CLR) begin
            state <= CLEAR;
            ptr   <= '0;
            BUSY  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr == LAST_PTR) begin
            state <= IDLE;
            ptr   <= '0;
            BUSY  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  br_read_mux #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rd1 (
    .ar   (AR1),
    .aw   (AW),
    .wr_ok(wr_ok),
    .din  (DataIn),
    .regs (mem),
    .dr   (DR1)
  );

  br_read_mux #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rd2 (
    .ar   (AR2),
    .aw   (AW),
    .wr_ok(wr_ok),
    .din  (DataIn),
    .regs (mem),
    .dr   (DR2)
  );

endmodule
